// File: rtl/v3a_deq_unit_pkg.sv
// Shared definitions for the tagged dequeue unit: shift command encoding and FSM states.
package v3a_QueuePkg;

   localparam logic [1:0] SHIFT_HOLD = 2'b00;
   localparam logic [1:0] SHIFT_FWD  = 2'b01;
   localparam logic [1:0] SHIFT_REV  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_RESP   = 2'd2
   } deq_state_t;

endpackage

// File: rtl/v3a_deq_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module v3a_deq_prio_enc #(
   parameter int p_width = 32,
   parameter int p_idxw  = (p_width > 1) ? $clog2(p_width) : 1
) (
   input  logic [p_width-1:0] i_req,
   output logic               o_found,
   output logic [p_idxw-1:0]  o_idx
);

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = p_width - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_found = 1'b1;
            o_idx   = p_idxw'(i);
         end
      end
   end

endmodule

// File: rtl/v3a_deq_unit.sv
// Tagged dequeue: finds the oldest occupied entry with a matching tag, compacts the
// queue behind it by one slot and returns its payload over a valid/ready response.
//
// state  | meaning
// IDLE   | ready for a request; tag latched on deq_val
// SEARCH | one-cycle compare; drives shift_en/clr_occ/wr_lock
// RESP   | response held until resp_rdy
module v3a_deq_unit
   import v3a_QueuePkg::*;
#(
   parameter int p_depth     = 32,
   parameter int p_ptrwidth  = $clog2(p_depth),
   parameter int p_chanwidth = 32,
   parameter int p_bitwidth  = p_ptrwidth + p_chanwidth
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 deq_val,
   output logic                                 deq_rdy,
   input  logic [p_ptrwidth-1:0]                deq_tag,
   output logic                                 resp_val,
   input  logic                                 resp_rdy,
   output logic                                 resp_hit,
   output logic [p_chanwidth-1:0]               resp_data,
   input  logic [p_depth-1:0][p_bitwidth-1:0]   data_in,
   input  logic [p_depth-1:0]                   occ,
   output logic [p_depth-1:0][1:0]              shift_en,
   output logic [p_depth-1:0]                   clr_occ,
   output logic                                 wr_lock
);

   localparam int lp_idxw = (p_depth > 1) ? $clog2(p_depth) : 1;

   deq_state_t              r_state;
   deq_state_t              w_state_nxt;
   logic                    r_deq_rdy;
   logic                    r_resp_val;
   logic                    r_hit;
   logic [p_chanwidth-1:0]  r_data;
   logic [p_ptrwidth-1:0]   r_tag;

   logic [p_depth-1:0]      w_match;
   logic [p_depth-1:0]      w_occ_rev;
   logic                    w_hit;
   logic                    w_any;
   logic [lp_idxw-1:0]      w_k;
   logic [lp_idxw-1:0]      w_m_rev;
   logic [lp_idxw-1:0]      w_m;
   logic [p_chanwidth-1:0]  w_k_data;
   logic                    w_search;
   logic                    w_accept;

   always_comb begin
      for (int i = 0; i < p_depth; i++) begin
         w_match[i]   = occ[i] && (data_in[i][p_bitwidth-1:p_chanwidth] == r_tag);
         w_occ_rev[i] = occ[p_depth-1-i];
      end
   end

   v3a_deq_prio_enc #(.p_width(p_depth), .p_idxw(lp_idxw)) u_match_enc (
      .i_req   (w_match),
      .o_found (w_hit),
      .o_idx   (w_k)
   );

   // Highest occupied slot: lowest set bit of the bit-reversed occupancy.
   v3a_deq_prio_enc #(.p_width(p_depth), .p_idxw(lp_idxw)) u_tail_enc (
      .i_req   (w_occ_rev),
      .o_found (w_any),
      .o_idx   (w_m_rev)
   );

   assign w_m      = lp_idxw'(p_depth - 1) - w_m_rev;
   assign w_k_data = data_in[w_k][p_chanwidth-1:0];
   assign w_accept = deq_val && r_deq_rdy;
   // Gated by rst so a reset landing in SEARCH never commits a shift or clear.
   assign w_search = (r_state == ST_SEARCH) && rst;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      shift_en    = '0;
      clr_occ     = '0;
      wr_lock     = 1'b0;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = ST_SEARCH;
         ST_SEARCH: w_state_nxt = ST_RESP;
         ST_RESP:   if (resp_rdy) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (w_search) begin
         wr_lock = 1'b1;
         if (w_hit && w_any) begin
            clr_occ[w_m] = 1'b1;
            for (int j = 0; j < p_depth; j++) begin
               if ((lp_idxw'(j) >= w_k) && (lp_idxw'(j) < w_m)) shift_en[j] = SHIFT_REV;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_deq_rdy  <= 1'b0;
         r_resp_val <= 1'b0;
         r_hit      <= 1'b0;
         r_data     <= '0;
         r_tag      <= '0;
      end else begin
         r_deq_rdy  <= (w_state_nxt == ST_IDLE);
         r_resp_val <= (w_state_nxt == ST_RESP);
         if (r_state == ST_IDLE && w_accept) r_tag <= deq_tag;
         if (r_state == ST_SEARCH) begin
            r_hit  <= w_hit;
            r_data <= w_hit ? w_k_data : '0;
         end
      end
   end

   assign deq_rdy   = r_deq_rdy;
   assign resp_val  = r_resp_val;
   assign resp_hit  = r_hit;
   assign resp_data = r_data;

endmodule

// File: tb/tb_v3a_deq_unit.sv
// Scoreboard bench for v3a_deq_unit at depth 4, 2-bit tags, 8-bit payloads.
module tb_v3a_deq_unit;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             deq_val = 1'b0;
   logic             deq_rdy;
   logic [1:0]       deq_tag = '0;
   logic             resp_val;
   logic             resp_rdy = 1'b0;
   logic             resp_hit;
   logic [7:0]       resp_data;
   logic [3:0][9:0]  data_in = '0;
   logic [3:0]       occ = '0;
   logic [3:0][1:0]  shift_en;
   logic [3:0]       clr_occ;
   logic             wr_lock;

   int               checks = 0;
   int               errors = 0;
   logic [8:0]       sb[$];

   v3a_deq_unit #(.p_depth(4), .p_ptrwidth(2), .p_chanwidth(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .deq_val   (deq_val),
      .deq_rdy   (deq_rdy),
      .deq_tag   (deq_tag),
      .resp_val  (resp_val),
      .resp_rdy  (resp_rdy),
      .resp_hit  (resp_hit),
      .resp_data (resp_data),
      .data_in   (data_in),
      .occ       (occ),
      .shift_en  (shift_en),
      .clr_occ   (clr_occ),
      .wr_lock   (wr_lock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst && resp_val && resp_rdy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=hit%0b/%0h required=none", resp_hit, resp_data);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            chk("resp_hit", 32'(resp_hit), 32'(e[8]));
            chk("resp_data", 32'(resp_data), 32'(e[7:0]));
         end
      end
   end

   task automatic load(input logic [3:0] o, input logic [1:0] t0, t1, t2, t3,
                       input logic [7:0] p0, p1, p2, p3);
      occ        = o;
      data_in[0] = {t0, p0};
      data_in[1] = {t1, p1};
      data_in[2] = {t2, p2};
      data_in[3] = {t3, p3};
   endtask

   task automatic wait_rdy(input string name, output logic ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!deq_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = deq_rdy;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_rdy_timeout actual=0 required=1", name);
      end
   endtask

   task automatic do_req(input string name, input logic [1:0] tag, input logic exp_hit,
                         input logic [7:0] exp_data, input logic [7:0] exp_shift,
                         input logic [3:0] exp_clr, input int stall);
      logic ok;
      wait_rdy(name, ok);
      if (!ok) return;
      deq_val = 1'b1;
      deq_tag = tag;
      sb.push_back({exp_hit, exp_data});
      @(posedge clk); #1;
      deq_val = 1'b0;
      @(negedge clk);
      chk({name, "_search_shift"}, 32'(shift_en), 32'(exp_shift));
      chk({name, "_search_clr"}, 32'(clr_occ), 32'(exp_clr));
      chk({name, "_search_lock"}, 32'(wr_lock), 32'd1);
      chk({name, "_search_rdy"}, 32'(deq_rdy), 32'd0);
      chk({name, "_search_val"}, 32'(resp_val), 32'd0);
      @(negedge clk);
      chk({name, "_resp_val"}, 32'(resp_val), 32'd1);
      chk({name, "_resp_lock"}, 32'(wr_lock), 32'd0);
      chk({name, "_resp_shift"}, 32'(shift_en), 32'd0);
      chk({name, "_resp_clr"}, 32'(clr_occ), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk({name, "_stall_val"}, 32'(resp_val), 32'd1);
         chk({name, "_stall_hit"}, 32'(resp_hit), 32'(exp_hit));
         chk({name, "_stall_data"}, 32'(resp_data), 32'(exp_data));
         chk({name, "_stall_rdy"}, 32'(deq_rdy), 32'd0);
      end
      @(posedge clk); #1;
      resp_rdy = 1'b1;
      @(posedge clk); #1;
      resp_rdy = 1'b0;
      @(negedge clk);
      chk({name, "_idle_val"}, 32'(resp_val), 32'd0);
      chk({name, "_idle_rdy"}, 32'(deq_rdy), 32'd1);
      chk({name, "_idle_lock"}, 32'(wr_lock), 32'd0);
   endtask

   initial begin
      logic ok;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_deq_rdy", 32'(deq_rdy), 32'd0);
      chk("rst_resp_val", 32'(resp_val), 32'd0);
      chk("rst_resp_hit", 32'(resp_hit), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_wr_lock", 32'(wr_lock), 32'd0);
      chk("rst_shift", 32'(shift_en), 32'd0);
      chk("rst_clr", 32'(clr_occ), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Two matches (0 and 2): lowest wins, REV over 0..2, clear tail slot 3.
      load(4'b1111, 2'd1, 2'd2, 2'd1, 2'd3, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
      do_req("t_multi", 2'd1, 1'b1, 8'hA0, 8'h2A, 4'b1000, 0);

      // k == m == 2; unoccupied slot 3 also carries tag 2 and must be ignored. Stall 5.
      load(4'b0111, 2'd0, 2'd1, 2'd2, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44);
      do_req("t_last", 2'd2, 1'b1, 8'h33, 8'h00, 4'b0100, 5);

      load(4'b1111, 2'd0, 2'd1, 2'd2, 2'd0, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
      do_req("t_miss", 2'd3, 1'b0, 8'h00, 8'h00, 4'b0000, 1);

      load(4'b0000, 2'd0, 2'd2, 2'd1, 2'd3, 8'h12, 8'h55, 8'h34, 8'h56);
      do_req("t_empty", 2'd2, 1'b0, 8'h00, 8'h00, 4'b0000, 0);

      // Hole at slot 2 between k=1 and m=3 still receives REV.
      load(4'b1011, 2'd0, 2'd1, 2'd1, 2'd2, 8'h10, 8'h20, 8'h30, 8'h40);
      do_req("t_hole", 2'd1, 1'b1, 8'h20, 8'h28, 4'b1000, 2);

      // Reset during SEARCH aborts: no clear, no shift, no response.
      load(4'b1111, 2'd1, 2'd2, 2'd1, 2'd3, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
      wait_rdy("t_abort", ok);
      if (ok) begin
         deq_val = 1'b1;
         deq_tag = 2'd1;
         @(posedge clk); #1;
         deq_val = 1'b0;
         rst     = 1'b0;
         @(negedge clk);
         chk("abort_clr", 32'(clr_occ), 32'd0);
         chk("abort_shift", 32'(shift_en), 32'd0);
         chk("abort_lock", 32'(wr_lock), 32'd0);
         @(negedge clk);
         chk("abort_rdy_low", 32'(deq_rdy), 32'd0);
         chk("abort_val_low", 32'(resp_val), 32'd0);
         @(posedge clk); #1;
         rst = 1'b1;
         @(negedge clk);
         chk("abort_clr2", 32'(clr_occ), 32'd0);
         @(negedge clk);
         chk("abort_rdy_back", 32'(deq_rdy), 32'd1);
         chk("abort_no_resp", 32'(resp_val), 32'd0);
         repeat (3) @(negedge clk);
         chk("abort_still_no_resp", 32'(resp_val), 32'd0);
      end

      do_req("t_after_abort", 2'd3, 1'b1, 8'hD3, 8'h00, 4'b1000, 0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
